// File: rtl/mu_fifo_pkg.sv
// Shared constants for the mu_fifo write-side arbiter.
package mu_fifo_pkg;

    // Arbiter FSM encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Extra bits on top of AW for the fifo_used + BURST space check
    localparam int unsigned SPACE_EXTRA_W = 2;

endpackage

// File: rtl/mu_fifo_wr_arb_if.sv
// Producer/FIFO-side bundle of the write arbiter. The master modport is the
// environment (producers and FIFO status); the slave modport is the arbiter.
interface mu_fifo_wr_arb_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic [DW-1:0]      fifo_din;
    logic               fifo_valid;
    logic               fifo_ready;
    logic [AW:0]        fifo_used;

    modport master (
        output req_valid, req_data, req_last, fifo_ready, fifo_used,
        input  req_ready, fifo_din, fifo_valid
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_ready, fifo_used,
        output req_ready, fifo_din, fifo_valid
    );
endinterface

// File: rtl/mu_rr_arbiter.sv
// Combinational round-robin pick: first valid requester searching upward
// from rr_ptr+1 (mod NREQ).
module mu_rr_arbiter #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IW-1:0]   rr_ptr,
    output logic            found,
    output logic [IW-1:0]   idx
);

    // Scan candidates in priority order, keep the first hit
    always_comb begin
        int unsigned cand;
        cand  = 0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            cand = (int'(rr_ptr) + i) % NREQ;
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/mu_fifo_wr_arb.sv
// Write-side arbiter and burst scheduler for mu_fifo_async. Round-robin,
// burst-granular grants; a burst starts only when the FIFO can hold it whole.
// Optional stall-timeout release is built when MU_FIFO_ARB_TIMEOUT_EN is defined.
module mu_fifo_wr_arb
    import mu_fifo_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = 16,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned BURST   = 4,
    parameter int unsigned TIMEOUT = 15,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned IW     = $clog2(NREQ)
) (
    input  logic                  wr_clk,
    input  logic                  wr_nreset,
    mu_fifo_wr_arb_if.slave       bus,
    output logic [IW-1:0]         grant_id,
    output logic                  busy,
    output logic                  err_timeout
);

    localparam int unsigned SW = AW + SPACE_EXTRA_W;
    localparam int unsigned BW = $clog2(BURST + 1);

    // Reject configurations the scheduler cannot honour
    if (NREQ < 2) begin : g_bad_nreq
        $error("mu_fifo_wr_arb: NREQ must be >= 2");
    end
    if (BURST < 1 || BURST > DEPTH) begin : g_bad_burst
        $error("mu_fifo_wr_arb: BURST must be in 1..DEPTH");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mu_fifo_wr_arb: TIMEOUT must be >= 1");
    end

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [BW-1:0] beat_q, beat_d;

    logic          arb_found;
    logic [IW-1:0] arb_idx;
    logic [SW-1:0] space_sum;
    logic          space_ok;
    logic          in_xfer;
    logic          g_valid;
    logic          beat;
    logic          burst_end;
    logic          timeout_hit;

    logic [NREQ-1:0] ready_c;
    logic [DW-1:0]   din_c;
    logic            valid_c;

    mu_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr_q),
        .found     (arb_found),
        .idx       (arb_idx)
    );

    // Widened so fifo_used + BURST cannot wrap
    assign space_sum = SW'(bus.fifo_used) + SW'(BURST);
    assign space_ok  = (space_sum <= SW'(DEPTH));

    assign in_xfer   = (state_q == ST_XFER);
    assign g_valid   = bus.req_valid[grant_q];
    assign beat      = in_xfer && g_valid && bus.fifo_ready;
    assign burst_end = beat && (bus.req_last[grant_q] || (beat_q == BW'(BURST - 1)));

`ifdef MU_FIFO_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] stall_q, stall_d;
    logic          err_q;

    // Release on the cycle the stall count would reach TIMEOUT
    assign timeout_hit = in_xfer && !g_valid && (stall_q == TW'(TIMEOUT - 1));
    assign stall_d     = (in_xfer && !g_valid) ? stall_q + TW'(1) : '0;

    // Stall counter and sticky timeout flag
    always_ff @(posedge wr_clk or negedge wr_nreset) begin
        if (!wr_nreset) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= timeout_hit ? '0 : stall_d;
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_timeout = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Next-state: arbitrate in IDLE, count beats in XFER, one-cycle GAP
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_found && space_ok) begin
                    grant_d = arb_idx;
                    beat_d  = '0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (burst_end || timeout_hit) begin
                    rr_ptr_d = grant_q;
                    beat_d   = '0;
                    state_d  = ST_GAP;
                end else if (beat) begin
                    beat_d = beat_q + BW'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, grant and round-robin pointer registers
    always_ff @(posedge wr_clk or negedge wr_nreset) begin
        if (!wr_nreset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= IW'(NREQ - 1);
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
        end
    end

    // Pass-through datapath from the granted requester, gated outside XFER
    always_comb begin
        ready_c = '0;
        valid_c = 1'b0;
        din_c   = bus.req_data[grant_q*DW +: DW];
        if (in_xfer) begin
            valid_c          = g_valid;
            ready_c[grant_q] = bus.fifo_ready;
        end
    end

    assign bus.req_ready  = ready_c;
    assign bus.fifo_valid = valid_c;
    assign bus.fifo_din   = din_c;
    assign grant_id       = grant_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mu_fifo_wr_arb.sv
// Directed bench for mu_fifo_wr_arb (NREQ=4, DW=16, DEPTH=16, BURST=4, TIMEOUT=15).
module tb_mu_fifo_wr_arb;

    logic       wr_clk;
    logic       wr_nreset;
    logic [1:0] grant_id;
    logic       busy;
    logic       err_timeout;

    int vectors;
    int miscompares;

    mu_fifo_wr_arb_if #(.NREQ(4), .DW(16), .DEPTH(16)) bus ();

    mu_fifo_wr_arb #(
        .NREQ    (4),
        .DW      (16),
        .DEPTH   (16),
        .BURST   (4),
        .TIMEOUT (15)
    ) dut (
        .wr_clk      (wr_clk),
        .wr_nreset   (wr_nreset),
        .bus         (bus),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    // Advance one clock; land 2 time units after the rising edge
    task automatic step();
        @(posedge wr_clk);
        #2;
    endtask

    // Reset held across an edge, inputs idle, release just after an edge
    task automatic do_reset();
        wr_nreset      = 1'b0;
        bus.req_valid  = '0;
        bus.req_last   = '0;
        bus.req_data   = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        bus.fifo_ready = 1'b1;
        bus.fifo_used  = '0;
        @(posedge wr_clk);
        #2;
        wr_nreset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++;
        if ({busy, grant_id, bus.fifo_valid, bus.req_ready, err_timeout} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%0b gid=%0d fv=%0b rdy=%b err=%0b want all 0",
                     busy, grant_id, bus.fifo_valid, bus.req_ready, err_timeout);
        end
    endtask

    // Req 0 sends 3 beats, last on the third
    task automatic test_single_packet();
        do_reset();
        bus.req_valid = 4'b0001;
        #1;
        vectors++;
        if (bus.fifo_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_idle_fv: got %0b want 0", bus.fifo_valid);
        end
        step();
        for (int b = 0; b < 3; b++) begin
            bus.req_data[15:0] = 16'hB000 + 16'(b);
            bus.req_last[0]    = (b == 2);
            #1;
            vectors++;
            if (grant_id !== 2'd0 || bus.fifo_valid !== 1'b1 ||
                bus.fifo_din !== 16'hB000 + 16'(b) || bus.req_ready !== 4'b0001) begin
                miscompares++;
                $display("FAIL single_beat%0d: got gid=%0d fv=%0b din=%h rdy=%b want 0 1 %h 0001",
                         b, grant_id, bus.fifo_valid, bus.fifo_din, bus.req_ready,
                         16'hB000 + 16'(b));
            end
            step();
        end
        bus.req_valid = '0;
        bus.req_last  = '0;
        #1;
        vectors++;
        if (busy !== 1'b1 || bus.fifo_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_gap: got busy=%0b fv=%0b want 1 0", busy, bus.fifo_valid);
        end
        step();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_busy_fall: got %0b want 0", busy);
        end
    endtask

    // All four valid, no last: 0,1,2,3,0 with 4 beats each and 2 idle cycles between
    task automatic test_round_robin();
        logic [1:0] g;
        do_reset();
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            g = 2'(k % 4);
            step();
            for (int b = 0; b < 4; b++) begin
                #1;
                vectors++;
                if (grant_id !== g || bus.fifo_valid !== 1'b1 ||
                    bus.fifo_din !== 16'hA000 + 16'(g) || bus.req_ready !== 4'b0001 << g) begin
                    miscompares++;
                    $display("FAIL rr_burst%0d_beat%0d: got gid=%0d fv=%0b din=%h rdy=%b want gid=%0d",
                             k, b, grant_id, bus.fifo_valid, bus.fifo_din, bus.req_ready, g);
                end
                step();
            end
            vectors++;
            if (busy !== 1'b1 || bus.fifo_valid !== 1'b0 || bus.req_ready !== 4'b0) begin
                miscompares++;
                $display("FAIL rr_gap%0d: got busy=%0b fv=%0b rdy=%b want 1 0 0000",
                         k, busy, bus.fifo_valid, bus.req_ready);
            end
            step();
            vectors++;
            if (busy !== 1'b0 || bus.fifo_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rr_idle%0d: got busy=%0b fv=%0b want 0 0", k, busy, bus.fifo_valid);
            end
        end
    endtask

    // 13 + 4 > 16 blocks the grant, 12 + 4 = 16 allows it
    task automatic test_space_check();
        do_reset();
        bus.fifo_used = 5'd13;
        bus.req_valid = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if (busy !== 1'b0 || bus.fifo_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL space_full%0d: got busy=%0b fv=%0b want 0 0", c, busy, bus.fifo_valid);
            end
        end
        bus.fifo_used = 5'd12;
        step();
        #1;
        vectors++;
        if (busy !== 1'b1 || grant_id !== 2'd2 || bus.fifo_valid !== 1'b1 ||
            bus.fifo_din !== 16'hA002) begin
            miscompares++;
            $display("FAIL space_grant: got busy=%0b gid=%0d fv=%0b din=%h want 1 2 1 a002",
                     busy, grant_id, bus.fifo_valid, bus.fifo_din);
        end
    endtask

    // fifo_ready low 3 cycles after two beats; burst still ends after 4 beats
    task automatic test_ready_stall();
        do_reset();
        bus.req_valid = 4'b0001;
        step();
        step();
        step();
        bus.fifo_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (bus.fifo_valid !== 1'b1 || bus.req_ready !== 4'b0 || grant_id !== 2'd0 ||
                busy !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got fv=%0b rdy=%b gid=%0d busy=%0b want 1 0000 0 1",
                         c, bus.fifo_valid, bus.req_ready, grant_id, busy);
            end
            step();
        end
        bus.fifo_ready = 1'b1;
        step();
        #1;
        vectors++;
        if (bus.fifo_valid !== 1'b1 || bus.req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL stall_beat4: got fv=%0b rdy=%b want 1 0001", bus.fifo_valid, bus.req_ready);
        end
        step();
        vectors++;
        if (busy !== 1'b1 || bus.fifo_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_gap: got busy=%0b fv=%0b want 1 0", busy, bus.fifo_valid);
        end
    endtask

    // Granted requester 0 drops valid while requester 1 waits
    task automatic test_timeout();
        do_reset();
        bus.req_valid = 4'b0011;
        step();
        bus.req_valid = 4'b0010;
`ifdef MU_FIFO_ARB_TIMEOUT_EN
        for (int c = 0; c < 14; c++) begin
            step();
        end
        vectors++;
        if (busy !== 1'b1 || grant_id !== 2'd0 || err_timeout !== 1'b0 ||
            bus.req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL timeout_pre: got busy=%0b gid=%0d err=%0b rdy=%b want 1 0 0 0001",
                     busy, grant_id, err_timeout, bus.req_ready);
        end
        step();
        vectors++;
        if (busy !== 1'b1 || err_timeout !== 1'b1 || bus.req_ready !== 4'b0) begin
            miscompares++;
            $display("FAIL timeout_release: got busy=%0b err=%0b rdy=%b want 1 1 0000",
                     busy, err_timeout, bus.req_ready);
        end
        step();
        step();
        vectors++;
        if (grant_id !== 2'd1 || bus.fifo_valid !== 1'b1 || err_timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_next: got gid=%0d fv=%0b err=%0b want 1 1 1",
                     grant_id, bus.fifo_valid, err_timeout);
        end
`else
        for (int c = 0; c < 20; c++) begin
            step();
        end
        vectors++;
        if (busy !== 1'b1 || grant_id !== 2'd0 || err_timeout !== 1'b0 ||
            bus.req_ready !== 4'b0001 || bus.fifo_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_hold: got busy=%0b gid=%0d err=%0b rdy=%b fv=%0b want 1 0 0 0001 0",
                     busy, grant_id, err_timeout, bus.req_ready, bus.fifo_valid);
        end
`endif
    endtask

    // Async reset on beat 2 clears everything at once; rr restarts at requester 0
    task automatic test_reset_midburst();
        do_reset();
        bus.req_valid = 4'b1001;
        step();
        step();
        step();
        #1;
        wr_nreset = 1'b0;
        #1;
        vectors++;
        if ({busy, grant_id, bus.fifo_valid, bus.req_ready, err_timeout} !== 9'b0) begin
            miscompares++;
            $display("FAIL midreset_state: got busy=%0b gid=%0d fv=%0b rdy=%b err=%0b want all 0",
                     busy, grant_id, bus.fifo_valid, bus.req_ready, err_timeout);
        end
        @(posedge wr_clk);
        #2;
        wr_nreset = 1'b1;
        step();
        #1;
        vectors++;
        if (grant_id !== 2'd0 || busy !== 1'b1 || bus.req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL midreset_regrant: got gid=%0d busy=%0b rdy=%b want 0 1 0001",
                     grant_id, busy, bus.req_ready);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_space_check();
        test_ready_stall();
        test_timeout();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Runaway guard
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
